dualport_ram_clr: RTL and testbench

DUALPORT_RAM_CLR -- requirements
Module: dualport_ram_clr

---
 rtl/dualport_ram_clr.sv | 162 ++++++++++++++++
 tb/tb_dualport_ram_clr.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dualport_ram_clr.sv
// Simple dual-port RAM with byte write enables, 1- or 2-cycle registered reads and a
// sequential clear engine that zeroes every word after reset or on request.
module dualport_ram_clr #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned RD_LAT         = 1,
  parameter int unsigned COLLISION_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid,
  input  logic                    clr_req,
  output logic                    clr_busy
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    user_ok;
  logic                    rd_accept;
  logic                    wr_user;
  logic [DATA_WIDTH-1:0]   merged;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    pipe_valid;
  logic [DATA_WIDTH-1:0]   pipe_data;
  logic                    rvalid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  // Clear FSM: state register. Reset parks the engine at the start of a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StClear;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Clear FSM: next-state logic. clr_req is only looked at from IDLE.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d    = StClear;
          clr_addr_d = '0;
        end
      end
      StClear: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == LAST_ADDR) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Clear FSM: outputs and memory write-port steering.
  always_comb begin
    clr_busy  = (state_q == StClear) || rst;
    user_ok   = (state_q == StIdle) && !rst;
    rd_accept = re && user_ok;
    wr_user   = we && user_ok;
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = merged;
    if (!rst) begin
      if (state_q == StClear) begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q;
        mem_wdata = '0;
      end else if (wr_user) begin
        mem_we    = |wbe;
      end
    end
  end

  // Byte-merged write word: enabled bytes from wdata, the rest from the current word.
  always_comb begin
    merged = mem[waddr];
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (wbe[i]) begin
        merged[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  // Read word; in write-through mode a same-address write is forwarded.
  always_comb begin
    rd_word = mem[raddr];
    if ((COLLISION_MODE == 1) && wr_user && (raddr == waddr)) begin
      rd_word = merged;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_data_q;

    // The word is captured at the accept edge, so later writes do not affect it.
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
      end else begin
        s1_valid_q <= rd_accept;
        if (rd_accept) begin
          s1_data_q <= rd_word;
        end
      end
    end

    assign pipe_valid = s1_valid_q;
    assign pipe_data  = s1_data_q;
  end else begin : g_lat1
    assign pipe_valid = rd_accept;
    assign pipe_data  = rd_word;
  end

  // Output stage; rdata holds between completed reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= pipe_valid;
      if (pipe_valid) begin
        rdata_q <= pipe_data;
      end
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_dualport_ram_clr.sv
// Drives a default RAM (read-old, 1-cycle) and a write-through 2-cycle RAM with the same
// stimulus; a reference model feeds per-DUT expectation queues consumed by a monitor.
module tb_dualport_ram_clr;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0;
  logic [1:0]    wbe = '0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          re = 1'b0;
  logic [AW-1:0] raddr = '0;
  logic          clr_req = 1'b0;

  logic [1:0][DW-1:0] rdata_v;
  logic [1:0]         rvalid_v;
  logic [1:0]         clr_busy_v;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] mem_m [DEPTH];
  int            busy_left = 0;
  int            cyc = 0;
  bit            started = 0;
  exp_t          expq [2][$];
  logic [DW-1:0] last_v [2];

  always #5 clk = ~clk;

  dualport_ram_clr #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(1), .COLLISION_MODE(0)
  ) dut0 (
    .clk(clk), .rst(rst), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata_v[0]), .rvalid(rvalid_v[0]),
    .clr_req(clr_req), .clr_busy(clr_busy_v[0])
  );

  dualport_ram_clr #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(2), .COLLISION_MODE(1)
  ) dut1 (
    .clk(clk), .rst(rst), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata_v[1]), .rvalid(rvalid_v[1]),
    .clr_req(clr_req), .clr_busy(clr_busy_v[1])
  );

  // Model: a clear wipes the array as a whole and then blocks users for DEPTH edges.
  initial begin
    logic [DW-1:0] old_w, new_w;
    exp_t          e;
    forever begin
      @(posedge clk);
      cyc++;
      started = 1;
      if (rst) begin
        busy_left = DEPTH;
        for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
        expq[0].delete();
        expq[1].delete();
        last_v[0] = '0;
        last_v[1] = '0;
      end else if (busy_left > 0) begin
        busy_left--;
      end else begin
        new_w = mem_m[waddr];
        for (int b = 0; b < DW / 8; b++) begin
          if (wbe[b]) new_w[8*b +: 8] = wdata[8*b +: 8];
        end
        if (re) begin
          old_w = mem_m[raddr];
          e.data = old_w;
          e.due  = cyc;
          expq[0].push_back(e);
          e.data = (we && raddr == waddr) ? new_w : old_w;
          e.due  = cyc + 1;
          expq[1].push_back(e);
        end
        if (we) mem_m[waddr] = new_w;
        if (clr_req) begin
          for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
          busy_left = DEPTH;
        end
      end
    end
  end

  // Monitor: compares both DUTs against the model away from the active edge.
  initial begin
    exp_t e;
    logic exp_busy;
    forever begin
      @(negedge clk);
      if (started) begin
        exp_busy = (busy_left > 0) || rst;
        for (int d = 0; d < 2; d++) begin
          checks++;
          if (clr_busy_v[d] !== exp_busy) begin
            errors++;
            $display("FAIL clr_busy dut%0d cyc %0d: got %b expected %b", d, cyc,
                     clr_busy_v[d], exp_busy);
          end
          if (rvalid_v[d] === 1'b1) begin
            checks++;
            if (expq[d].size() == 0) begin
              errors++;
              $display("FAIL rvalid dut%0d cyc %0d: got unexpected pulse, expected none", d, cyc);
            end else begin
              e = expq[d].pop_front();
              last_v[d] = e.data;
              if (rdata_v[d] !== e.data || e.due != cyc) begin
                errors++;
                $display("FAIL rdata dut%0d cyc %0d: got %h expected %h due cyc %0d", d, cyc,
                         rdata_v[d], e.data, e.due);
              end
            end
          end else begin
            checks++;
            if (rdata_v[d] !== last_v[d] || rvalid_v[d] !== 1'b0) begin
              errors++;
              $display("FAIL rdata_hold dut%0d cyc %0d: got %h/%b expected %h/0", d, cyc,
                       rdata_v[d], rvalid_v[d], last_v[d]);
            end
            if (expq[d].size() != 0 && expq[d][0].due <= cyc) begin
              checks++;
              errors++;
              e = expq[d].pop_front();
              $display("FAIL rvalid_missing dut%0d cyc %0d: got no pulse expected data %h", d,
                       cyc, e.data);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    rst = 1'b0; we = 1'b0; wbe = '0; re = 1'b0; clr_req = 1'b0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input logic [1:0] be);
    we = 1'b1; waddr = AW'(a); wdata = d; wbe = be;
  endtask

  task automatic rd(input int a);
    re = 1'b1; raddr = AW'(a);
  endtask

  initial begin
    // Reset release, then wait out the power-on clear and read back zero.
    rst = 1'b1; tick();
    rst = 1'b1; tick();
    repeat (17) tick();
    rd(9); tick();
    rd(0); tick();
    tick();

    // Byte enables
    wr(3, 16'hABCD, 2'b11); tick();
    wr(3, 16'h12FF, 2'b01); tick();
    wr(3, 16'h9999, 2'b00); tick();
    rd(3); tick();
    tick();

    // Collision, then plain re-read
    wr(5, 16'h1111, 2'b11); tick();
    wr(5, 16'h2222, 2'b11); rd(5); tick();
    rd(5); tick();
    wr(6, 16'h3456, 2'b10); rd(6); tick();
    tick(); tick();

    // Back-to-back reads
    rd(0); tick();
    rd(1); tick();
    rd(2); tick();
    tick(); tick();

    // Fill, clear with a read on the entry edge, and try accesses during the clear.
    for (int a = 0; a < DEPTH; a++) begin wr(a, 16'hFFFF, 2'b11); tick(); end
    clr_req = 1'b1; rd(4); tick();
    wr(7, 16'h5555, 2'b11); rd(7); tick();
    clr_req = 1'b1; tick();
    repeat (15) tick();
    for (int a = 0; a < DEPTH; a++) begin rd(a); tick(); end
    tick(); tick();

    // Reset at clear cycle 8
    wr(2, 16'hBEEF, 2'b11); tick();
    clr_req = 1'b1; tick();
    repeat (8) tick();
    rst = 1'b1; tick();
    repeat (17) tick();
    rd(2); tick();

    // Reset while a 2-cycle read is in flight
    wr(1, 16'h7777, 2'b11); tick();
    rd(1); tick();
    rst = 1'b1; tick();
    repeat (17) tick();

    // clr_req held high
    for (int i = 0; i < 40; i++) begin clr_req = 1'b1; rd(i % DEPTH); tick(); end
    repeat (17) tick();

    // Randomized traffic on a narrow address window to provoke collisions
    for (int i = 0; i < 800; i++) begin
      we      = 1'($urandom_range(0, 1));
      wbe     = 2'($urandom_range(0, 3));
      waddr   = AW'($urandom_range(0, 3));
      wdata   = DW'($urandom);
      re      = ($urandom_range(0, 3) != 0);
      raddr   = AW'($urandom_range(0, 3));
      clr_req = ($urandom_range(0, 59) == 0);
      rst     = ($urandom_range(0, 249) == 0);
      @(posedge clk);
      #2;
    end
    rst = 1'b0; we = 1'b0; re = 1'b0; clr_req = 1'b0; wbe = '0;
    repeat (20) tick();

    for (int d = 0; d < 2; d++) begin
      checks++;
      if (expq[d].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d: got %0d outstanding reads expected 0", d, expq[d].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
